// File: rtl/vga_pkg.sv
// Shared widths, defaults, state encoding and the per-axis bounce rule
// for the VGA sprite overlay.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int COORD_W      = 10;
    localparam int RGB_W        = 12;

    typedef enum logic [1:0] {
        HIDDEN = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } spr_state_e;

    // One axis of sprite motion: top-left coordinate plus travel direction.
    typedef struct packed {
        logic [COORD_W-1:0] pos;
        logic               neg;   // 1 = moving toward 0
    } axis_t;

    // Advance one axis by one step, bouncing off 0 and lim-size.
    // Carried at COORD_W+1 bits so pos+size+step cannot wrap.
    function automatic axis_t axis_move(input axis_t              a,
                                        input logic [COORD_W:0]   lim,
                                        input logic [COORD_W:0]   size,
                                        input logic [COORD_W:0]   step);
        axis_t            r;
        logic [COORD_W:0] p;
        r = a;
        p = {1'b0, a.pos};
        if (!a.neg) begin
            if (p + size + step >= lim) begin
                r.pos = COORD_W'(lim - size);
                r.neg = 1'b1;
            end else begin
                r.pos = COORD_W'(p + step);
            end
        end else begin
            if (p <= step) begin
                r.pos = '0;
                r.neg = 1'b0;
            end else begin
                r.pos = COORD_W'(p - step);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_sprite_overlay_if.sv
// Pixel request / response bundle between vga_driver, the background
// generator and the sprite overlay stage.
interface vga_sprite_overlay_if;
    import vga_pkg::*;

    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [RGB_W-1:0]   bg_data;
    logic               sprite_en;
    logic               freeze;
    logic [RGB_W-1:0]   sprite_rgb;
    logic [RGB_W-1:0]   pixel_data;
    logic               frame_tick;

    modport master (
        output pixel_x, pixel_y, bg_data, sprite_en, freeze, sprite_rgb,
        input  pixel_data, frame_tick
    );

    modport slave (
        input  pixel_x, pixel_y, bg_data, sprite_en, freeze, sprite_rgb,
        output pixel_data, frame_tick
    );

endinterface

// File: rtl/vga_frame_tick.sv
// End-of-frame detector and frame divider: one frame_tick per frame, and
// move_evt on the tick that completes FRAME_DIV counted frames.
module vga_frame_tick
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int FRAME_DIV = 1
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic [COORD_W-1:0] pixel_x,
    input  logic [COORD_W-1:0] pixel_y,
    input  logic               cnt_en,     // divider advances only while running
    output logic               frame_tick,
    output logic               move_evt
);

    logic       end_pix;
    logic       end_pix_q;
    logic [7:0] div_cnt;
    logic       div_last;

    assign end_pix  = (pixel_x == COORD_W'(H_ACTIVE - 1)) &&
                      (pixel_y == COORD_W'(V_ACTIVE - 1));
    assign div_last = (div_cnt == 8'(FRAME_DIV - 1));
    assign move_evt = frame_tick && cnt_en && div_last;

    // Rising edge of end_pix, so a driver parked on the last pixel ticks once.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            end_pix_q  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            end_pix_q  <= end_pix;
            frame_tick <= end_pix && !end_pix_q;
        end
    end

    // Frame divider; held whenever the sprite is not running.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt <= '0;
        end else if (frame_tick && cnt_en) begin
            div_cnt <= div_last ? 8'd0 : div_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/vga_sprite_overlay.sv
// Overlays a bouncing solid square sprite on the background pixel stream;
// pixel_data is registered, one cycle after pixel_x/pixel_y/bg_data.
module vga_sprite_overlay
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int SIZE      = 32,
    parameter int STEP      = 4,
    parameter int FRAME_DIV = 1,
    parameter int X0        = 100,
    parameter int Y0        = 100
) (
    input  logic                  vga_clk,
    input  logic                  sys_rst_n,
    vga_sprite_overlay_if.slave   bus
);

    localparam logic [COORD_W:0] H_LIM = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] V_LIM = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W:0] SZ    = (COORD_W+1)'(SIZE);
    localparam logic [COORD_W:0] STP   = (COORD_W+1)'(STEP);

    spr_state_e       state;
    axis_t            ax;
    axis_t            ay;
    logic             frame_tick;
    logic             move_evt;
    logic             running;
    logic             hit;
    logic [COORD_W:0] px_w;
    logic [COORD_W:0] py_w;
    logic [COORD_W:0] x_w;
    logic [COORD_W:0] y_w;

    assign running        = (state == RUN);
    assign bus.frame_tick = frame_tick;

    vga_frame_tick #(
        .H_ACTIVE  (H_ACTIVE),
        .V_ACTIVE  (V_ACTIVE),
        .FRAME_DIV (FRAME_DIV)
    ) u_tick (
        .vga_clk    (vga_clk),
        .sys_rst_n  (sys_rst_n),
        .pixel_x    (bus.pixel_x),
        .pixel_y    (bus.pixel_y),
        .cnt_en     (running),
        .frame_tick (frame_tick),
        .move_evt   (move_evt)
    );

    // Hit test against the current (pre-update) position.
    always_comb begin
        px_w = {1'b0, bus.pixel_x};
        py_w = {1'b0, bus.pixel_y};
        x_w  = {1'b0, ax.pos};
        y_w  = {1'b0, ay.pos};
        hit  = (px_w >= x_w) && (px_w < x_w + SZ) &&
               (py_w >= y_w) && (py_w < y_w + SZ);
    end

    // Visibility / motion state; sprite_en takes priority over freeze.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= HIDDEN;
        end else begin
            case (state)
                HIDDEN:  if (bus.sprite_en) state <= RUN;
                RUN:     if (!bus.sprite_en) state <= HIDDEN;
                         else if (bus.freeze) state <= FROZEN;
                FROZEN:  if (!bus.sprite_en) state <= HIDDEN;
                         else if (!bus.freeze) state <= RUN;
                default: state <= HIDDEN;
            endcase
        end
    end

    // Sprite motion: one step per axis on each move event while running.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ax <= axis_t'{pos: COORD_W'(X0), neg: 1'b0};
            ay <= axis_t'{pos: COORD_W'(Y0), neg: 1'b0};
        end else if (move_evt) begin
            ax <= axis_move(ax, H_LIM, SZ, STP);
            ay <= axis_move(ay, V_LIM, SZ, STP);
        end
    end

    // Registered pixel merge.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bus.pixel_data <= '0;
        end else begin
            bus.pixel_data <= (state != HIDDEN && hit) ? bus.sprite_rgb : bus.bg_data;
        end
    end

endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed + randomized bench for vga_sprite_overlay: two instances
// (FRAME_DIV=1 and FRAME_DIV=3) share stimulus and are checked every cycle
// against a frame-level reference model of the sprite.
module tb_vga_sprite_overlay;

    localparam int H = 640, V = 480, SZ = 32, ST = 4;

    logic       vga_clk;
    logic       sys_rst_n;
    logic [9:0] px, py;
    logic [11:0] bg, rgb;
    logic       en, frz;

    int tests = 0;
    int fails = 0;

    vga_sprite_overlay_if bus0 ();
    vga_sprite_overlay_if bus1 ();

    assign bus0.pixel_x = px;  assign bus1.pixel_x = px;
    assign bus0.pixel_y = py;  assign bus1.pixel_y = py;
    assign bus0.bg_data = bg;  assign bus1.bg_data = bg;
    assign bus0.sprite_en = en;  assign bus1.sprite_en = en;
    assign bus0.freeze = frz;  assign bus1.freeze = frz;
    assign bus0.sprite_rgb = rgb;  assign bus1.sprite_rgb = rgb;

    vga_sprite_overlay #(.FRAME_DIV(1)) u_dut0 (
        .vga_clk (vga_clk), .sys_rst_n (sys_rst_n), .bus (bus0.slave));
    vga_sprite_overlay #(.FRAME_DIV(3)) u_dut1 (
        .vga_clk (vga_clk), .sys_rst_n (sys_rst_n), .bus (bus1.slave));

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    // Reference model: 0 hidden, 1 running, 2 frozen.
    int mx[2], my[2], mdx[2], mdy[2], mcnt[2], mst[2];
    int mdiv[2] = '{1, 3};
    bit m_endq, m_tick;
    int exp_pix[2];
    bit exp_tick;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = 100; my[k] = 100; mdx[k] = 1; mdy[k] = 1;
            mcnt[k] = 0; mst[k] = 0;
        end
        m_endq = 0; m_tick = 0;
    endtask

    function automatic void bounce(inout int p, inout int d, input int lim);
        if (d > 0) begin
            if (p + SZ + ST >= lim) begin p = lim - SZ; d = -1; end
            else p = p + ST;
        end else begin
            if (p <= ST) begin p = 0; d = 1; end
            else p = p - ST;
        end
    endfunction

    // One clock: predict from the pre-edge model, advance it, then compare.
    task automatic cyc();
        bit endp, hitk;
        int x, y;
        x = int'(px); y = int'(py);
        endp = (x == H-1) && (y == V-1);
        for (int k = 0; k < 2; k++) begin
            hitk = (x >= mx[k]) && (x < mx[k] + SZ) && (y >= my[k]) && (y < my[k] + SZ);
            exp_pix[k] = (mst[k] != 0 && hitk) ? int'(rgb) : int'(bg);
            if (m_tick && mst[k] == 1) begin
                if (mcnt[k] == mdiv[k] - 1) begin
                    mcnt[k] = 0;
                    bounce(mx[k], mdx[k], H);
                    bounce(my[k], mdy[k], V);
                end else begin
                    mcnt[k]++;
                end
            end
            case (mst[k])
                0: if (en) mst[k] = 1;
                1: if (!en) mst[k] = 0; else if (frz) mst[k] = 2;
                default: if (!en) mst[k] = 0; else if (!frz) mst[k] = 1;
            endcase
        end
        exp_tick = endp && !m_endq;
        m_endq = endp;
        m_tick = exp_tick;
        @(posedge vga_clk); #1;
        chk("pix0", 16'(bus0.pixel_data), 16'(exp_pix[0]));
        chk("pix1", 16'(bus1.pixel_data), 16'(exp_pix[1]));
        chk("tick0", 16'(bus0.frame_tick), 16'(exp_tick));
        chk("tick1", 16'(bus1.frame_tick), 16'(exp_tick));
    endtask

    task automatic frame();
        px = 10'd639; py = 10'd479; cyc();
        px = 10'd0;   py = 10'd0;   cyc();
    endtask

    task automatic probe(input string tag, input int sel, input int x, input int y,
                         input logic [11:0] exp);
        px = 10'(x); py = 10'(y);
        cyc();
        if (sel == 0) chk(tag, 16'(bus0.pixel_data), 16'(exp));
        else          chk(tag, 16'(bus1.pixel_data), 16'(exp));
    endtask

    initial begin
        int ticks, sx, sy, r, cx, cy;
        sys_rst_n = 1'b0;
        px = 10'd5; py = 10'd7; bg = 12'hABC; rgb = 12'h000; en = 1'b0; frz = 1'b0;
        model_reset();

        // Reset state
        @(posedge vga_clk); #1;
        chk("rst_pix0", 16'(bus0.pixel_data), 16'h0);
        chk("rst_tick0", 16'(bus0.frame_tick), 16'h0);
        chk("rst_pix1", 16'(bus1.pixel_data), 16'h0);
        sys_rst_n = 1'b1;
        cyc();
        chk("rel_bg", 16'(bus0.pixel_data), 16'hABC);

        // Hit test at reset position
        en = 1'b1; rgb = 12'hF00; bg = 12'h00F;
        cyc();
        probe("hit_100_100", 0, 100, 100, 12'hF00);
        probe("hit_131_131", 0, 131, 131, 12'hF00);
        probe("miss_132_100", 0, 132, 100, 12'h00F);
        probe("miss_99_100", 0, 99, 100, 12'h00F);

        // Last pixel held for 3 cycles -> one tick, one move
        ticks = 0;
        px = 10'd639; py = 10'd479;
        for (int i = 0; i < 3; i++) begin cyc(); ticks += int'(bus0.frame_tick); end
        chk("one_tick", 16'(ticks), 16'd1);
        px = 10'd0; py = 10'd0; cyc();
        probe("moved_104", 0, 104, 104, 12'hF00);
        probe("moved_135", 0, 135, 135, 12'hF00);
        probe("moved_103", 0, 103, 104, 12'h00F);
        probe("moved_136", 0, 136, 104, 12'h00F);

        // Right-edge bounce
        for (int i = 0; i < 400 && !(mx[0] == 604 && mdx[0] > 0); i++) frame();
        frame();
        probe("redge_608", 0, 608, my[0], 12'hF00);
        probe("redge_607", 0, 607, my[0], 12'h00F);
        frame();
        probe("redge_back_604", 0, 604, my[0], 12'hF00);
        probe("redge_back_603", 0, 603, my[0], 12'h00F);

        // Left-edge bounce
        for (int i = 0; i < 400 && !(mx[0] <= ST && mdx[0] < 0); i++) frame();
        frame();
        probe("ledge_0", 0, 0, my[0], 12'hF00);
        probe("ledge_32", 0, 32, my[0], 12'h00F);
        frame();
        probe("ledge_4", 0, 4, my[0], 12'hF00);
        probe("ledge_3", 0, 3, my[0], 12'h00F);

        // Freeze for 5 frames, then resume
        frz = 1'b1; cyc();
        sx = mx[0]; sy = my[0];
        for (int i = 0; i < 5; i++) frame();
        probe("frz_corner", 0, sx, sy, 12'hF00);
        probe("frz_far", 0, sx + SZ - 1, sy + SZ - 1, 12'hF00);
        frz = 1'b0; cyc();
        frame();
        probe("resume", 0, mx[0], my[0], 12'hF00);

        // sprite_en dropped mid-line
        sx = mx[0]; sy = my[0];
        px = 10'(sx); py = 10'(sy);
        en = 1'b0; cyc();
        cyc();
        chk("hide_bg", 16'(bus0.pixel_data), 16'h00F);
        en = 1'b1; cyc();
        probe("hide_retained", 0, sx, sy, 12'hF00);

        // Reset mid-frame
        px = 10'(sx); py = 10'(sy);
        #10 sys_rst_n = 1'b0;
        #1;
        chk("midrst_pix0", 16'(bus0.pixel_data), 16'h0);
        chk("midrst_pix1", 16'(bus1.pixel_data), 16'h0);
        model_reset();
        @(posedge vga_clk); #1;
        sys_rst_n = 1'b1;
        cyc();
        chk("midrst_hidden", 16'(bus0.pixel_data), 16'h00F);
        cyc();
        probe("midrst_home", 0, 100, 100, 12'hF00);

        // FRAME_DIV = 3 instance
        frame(); frame();
        probe("div3_hold_a", 1, 100, 100, 12'hF00);
        probe("div3_hold_b", 1, 131, 131, 12'hF00);
        probe("div3_hold_c", 1, 132, 100, 12'h00F);
        frame();
        probe("div3_moved_old", 1, 100, 100, 12'h00F);
        probe("div3_moved_new", 1, 104, 104, 12'hF00);

        // Randomized traffic around the sprite
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 31));
            if (r == 0) en = ~en;
            if (r == 1) frz = ~frz;
            bg  = 12'($urandom);
            rgb = 12'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                px = 10'd639; py = 10'd479;
            end else begin
                cx = mx[0] + int'($urandom_range(0, 40)) - 4;
                cy = my[0] + int'($urandom_range(0, 40)) - 4;
                if ($urandom_range(0, 1) == 1) begin
                    cx = mx[1] + int'($urandom_range(0, 40)) - 4;
                    cy = my[1] + int'($urandom_range(0, 40)) - 4;
                end
                if (cx < 0) cx = 0;
                if (cx > H-1) cx = H-1;
                if (cy < 0) cy = 0;
                if (cy > V-1) cy = V-1;
                px = 10'(cx); py = 10'(cy);
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
